// File: rtl/l7_pkg.sv
// Shared constants and types for the layer-7 scan sequencer: phase codes,
// FSM state encoding and the delayed-coordinate bundle.
package l7_pkg;

  localparam int DIM_DEF   = 16;
  localparam int DELAY_DEF = 5;

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_LOAD   = 3'd1;
  localparam logic [2:0] PH_WRITE  = 3'd2;
  localparam logic [2:0] PH_KERNEL = 3'd3;
  localparam logic [2:0] PH_STORE  = 3'd4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DRAIN_W = 3'd3;
  localparam logic [2:0] S_KERNEL  = 3'd4;
  localparam logic [2:0] S_STORE   = 3'd5;
  localparam logic [2:0] S_DRAIN_S = 3'd6;

  typedef struct packed {
    logic       valid;
    logic [4:0] x;
    logic [4:0] y;
  } coord_t;

  // Drains report the phase they are draining so downstream decode stays put.
  function automatic logic [2:0] phase_of(input logic [2:0] state);
    case (state)
      S_LOAD:              phase_of = PH_LOAD;
      S_WRITE, S_DRAIN_W:  phase_of = PH_WRITE;
      S_KERNEL:            phase_of = PH_KERNEL;
      S_STORE, S_DRAIN_S:  phase_of = PH_STORE;
      default:             phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/coord_delay_L7.sv
// Enable-gated shift register that delays the {valid, x, y} bundle to line
// up with the MAC pipeline; synchronous clear.
module coord_delay_L7
  import l7_pkg::*;
#(
  parameter int DELAY = DELAY_DEF
) (
  input  logic   clk,
  input  logic   clr_i,
  input  logic   en_i,
  input  coord_t d_i,
  output coord_t q_o
);

  generate
    for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
      coord_t stage_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (clr_i)     stage_q <= '0;
          else if (en_i) stage_q <= d_i;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (clr_i)     stage_q <= '0;
          else if (en_i) stage_q <= g_stage[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign q_o = g_stage[DELAY-1].stage_q;

endmodule

// File: rtl/l7_scan_sequencer.sv
// Layer-7 loop sequencer: sweeps DIMxDIM tile coordinates through the
// load/write/kernel/store phases and emits a pipeline-aligned delayed copy.
module l7_scan_sequencer
  import l7_pkg::*;
#(
  parameter int DIM      = DIM_DEF,
  parameter int DELAY    = DELAY_DEF,
  parameter int K_PASSES = 3,
  parameter int Z_PASSES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic [4:0] x_Reg5,
  output logic [4:0] y_Reg5,
  output logic [2:0] u,
  output logic [1:0] k,
  output logic [1:0] z,
  output logic       L_zero,
  output logic       valid,
  output logic       valid_Reg5,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0]    LAST       = 5'(DIM - 1);
  localparam int            DW         = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DELAY - 1);
  localparam logic [1:0]    K_LAST     = 2'(K_PASSES - 1);
  localparam logic [1:0]    Z_LAST     = 2'(Z_PASSES - 1);

  logic [2:0]    state_q, state_d;
  logic [4:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    pass_q, pass_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          done_q, done_d;

  logic       wrap;
  logic [4:0] x_nx, y_nx;
  logic [1:0] last_pass;
  coord_t     live, delayed;

  assign wrap = (x_q == LAST) && (y_q == LAST);

  always_comb begin
    last_pass = 2'd0;
    case (state_q)
      S_LOAD:   last_pass = 2'd1;
      S_KERNEL: last_pass = K_LAST;
      S_STORE:  last_pass = Z_LAST;
      default:  last_pass = 2'd0;
    endcase
  end

  // y is the inner counter, x the outer.
  always_comb begin
    if (y_q == LAST) begin
      y_nx = 5'd0;
      x_nx = (x_q == LAST) ? 5'd0 : x_q + 5'd1;
    end else begin
      y_nx = y_q + 5'd1;
      x_nx = x_q;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pass_d  = pass_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          x_d     = 5'd0;
          y_d     = 5'd0;
          pass_d  = 2'd0;
        end
      end
      S_LOAD, S_WRITE, S_KERNEL, S_STORE: begin
        x_d = x_nx;
        y_d = y_nx;
        if (wrap) begin
          if (pass_q == last_pass) begin
            pass_d  = 2'd0;
            drain_d = '0;
            case (state_q)
              S_LOAD:   state_d = S_WRITE;
              S_KERNEL: state_d = S_STORE;
              S_WRITE: begin
                state_d = S_DRAIN_W;
                x_d     = x_q;
                y_d     = y_q;
              end
              default: begin
                // STORE drain keeps the final z visible.
                state_d = S_DRAIN_S;
                x_d     = x_q;
                y_d     = y_q;
                pass_d  = pass_q;
              end
            endcase
          end else begin
            pass_d = pass_q + 2'd1;
          end
        end
      end
      S_DRAIN_W: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_KERNEL;
          x_d     = 5'd0;
          y_d     = 5'd0;
          pass_d  = 2'd0;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DRAIN_S: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          x_d     = 5'd0;
          y_d     = 5'd0;
          pass_d  = 2'd0;
          drain_d = '0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Start is honoured in IDLE even under hold; everything else freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 5'd0;
      y_q     <= 5'd0;
      pass_q  <= 2'd0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!hold || state_q == S_IDLE) begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        pass_q  <= pass_d;
        drain_q <= drain_d;
        done_q  <= done_d;
      end
    end
  end

  assign live.valid = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                      (state_q == S_KERNEL) || (state_q == S_STORE);
  assign live.x = x_q;
  assign live.y = y_q;

  coord_delay_L7 #(.DELAY(DELAY)) u_delay (
    .clk   (clk),
    .clr_i (rst || (done_d && !hold)),
    .en_i  (!hold),
    .d_i   (live),
    .q_o   (delayed)
  );

  assign x          = x_q;
  assign y          = y_q;
  assign valid      = live.valid;
  assign x_Reg5     = delayed.x;
  assign y_Reg5     = delayed.y;
  assign valid_Reg5 = delayed.valid;
  assign u          = phase_of(state_q);
  assign k          = (state_q == S_KERNEL) ? pass_q + 2'd1 : 2'd0;
  assign z          = (state_q == S_STORE || state_q == S_DRAIN_S) ? pass_q : 2'd0;
  assign L_zero     = (state_q == S_LOAD) ? pass_q[0] : 1'b0;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_l7_scan_sequencer.sv
// Bench for l7_scan_sequencer: each run is compared cycle by cycle with a
// schedule computed arithmetically from the phase lengths.
module tb_l7_scan_sequencer;

  localparam int D    = 16;
  localparam int S    = D * D;
  localparam int DL   = 5;
  localparam int W0   = 2 * S + 1;
  localparam int DW0  = 3 * S + 1;
  localparam int K0   = DW0 + DL;
  localparam int S0   = K0 + 3 * S;
  localparam int DS0  = S0 + 3 * S;
  localparam int LAST = DS0 + DL - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic [4:0] x, y, x_Reg5, y_Reg5;
  logic [2:0] u;
  logic [1:0] k, z;
  logic L_zero, valid, valid_Reg5, busy, done;

  int total = 0;
  int bad = 0;

  wire [31:0] obs = {busy, done, u, k, z, L_zero, valid, x, y, valid_Reg5, x_Reg5, y_Reg5};

  l7_scan_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .x(x), .y(y), .x_Reg5(x_Reg5), .y_Reg5(y_Reg5),
    .u(u), .k(k), .z(z), .L_zero(L_zero),
    .valid(valid), .valid_Reg5(valid_Reg5), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {u, k, z, L_zero, valid, x, y} at effective run cycle n (n=1 is first busy cycle).
  function automatic logic [18:0] base(int n);
    int i, xi, yi;
    logic [2:0] pu;
    logic [1:0] pk, pz;
    logic pl, pv;
    pu = 0; pk = 0; pz = 0; pl = 0; pv = 0; xi = 0; yi = 0;
    if (n >= 1 && n < W0) begin
      i = n - 1; pu = 1; pl = (i >= S); pv = 1; xi = (i % S) / D; yi = i % D;
    end else if (n >= W0 && n < DW0) begin
      i = n - W0; pu = 2; pv = 1; xi = i / D; yi = i % D;
    end else if (n >= DW0 && n < K0) begin
      pu = 2; xi = D - 1; yi = D - 1;
    end else if (n >= K0 && n < S0) begin
      i = n - K0; pu = 3; pk = 2'(i / S + 1); pv = 1; xi = (i % S) / D; yi = i % D;
    end else if (n >= S0 && n < DS0) begin
      i = n - S0; pu = 4; pz = 2'(i / S); pv = 1; xi = (i % S) / D; yi = i % D;
    end else if (n >= DS0 && n <= LAST) begin
      pu = 4; pz = 2; xi = D - 1; yi = D - 1;
    end
    return {pu, pk, pz, pl, pv, 5'(xi), 5'(yi)};
  endfunction

  function automatic logic [31:0] exp_at(int n);
    logic [18:0] b, d;
    logic eb, ed;
    b  = base(n);
    eb = (n >= 1 && n <= LAST);
    d  = eb ? base(n - DL) : 19'd0;
    ed = (n == LAST + 1);
    return {eb, ed, b, d[10:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int b0;
    b0 = bad;
    rst = 1'b1;
    hold = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== 32'd0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, obs, 32'd0);
      end
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    tick();
    total++;
    if (obs !== 32'd0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h exp=%h", obs, 32'd0);
    end
    $display("test_reset: errors=%0d", bad - b0);
  endtask

  // One full sequence; optional hold window, stray start pulse, start under hold,
  // or an abort via rst at effective cycle rst_at.
  task automatic run_seq(input string name, input int hold_at, input int hold_len,
                         input int extra_start, input bit start_hold, input int rst_at);
    int neff, busy_cnt, done_cnt, done_c, hrem, b0;
    logic [31:0] e;
    b0 = bad;
    start = 1'b1; hold = start_hold;
    tick();
    start = 1'b0; hold = 1'b0;
    neff = 1; hrem = hold_len; busy_cnt = 0; done_cnt = 0; done_c = -1;
    for (int c = 1; c <= 2700 && neff <= LAST + 3; c++) begin
      e = exp_at(neff);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s_seq c=%0d n=%0d got=%h exp=%h", name, c, neff, obs, e);
      end
      if (hold_len == 0) begin
        if (c == 257) begin
          total++;
          if (L_zero !== 1'b1) begin bad++; $display("FAIL %s_lzero_flip got=%b exp=1", name, L_zero); end
        end
        if (c == 773) begin
          total++;
          if ({valid_Reg5, x_Reg5, y_Reg5, valid} !== {1'b1, 5'd15, 5'd15, 1'b0}) begin
            bad++;
            $display("FAIL %s_drain_w_tail got=%b/%0d/%0d/%b exp=1/15/15/0", name, valid_Reg5, x_Reg5, y_Reg5, valid);
          end
        end
        if (c == 774) begin
          total++;
          if (u !== 3'd3) begin bad++; $display("FAIL %s_kernel_entry got=%0d exp=3", name, u); end
        end
        if (c == 1286) begin
          total++;
          if (k !== 2'd3) begin bad++; $display("FAIL %s_k3_entry got=%0d exp=3", name, k); end
        end
      end
      busy_cnt += int'(busy);
      if (done === 1'b1) begin done_cnt++; done_c = c; end
      if (rst_at > 0 && neff == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (obs !== 32'd0) begin
          bad++;
          $display("FAIL %s_abort got=%h exp=%h", name, obs, 32'd0);
        end
        $display("%s: aborted at n=%0d errors=%0d", name, neff, bad - b0);
        return;
      end
      start = (c == extra_start);
      if (neff == hold_at && hrem > 0) begin
        hold = 1'b1; hrem--;
      end else begin
        hold = 1'b0; neff++;
      end
      tick();
    end
    hold = 1'b0; start = 1'b0;
    total++;
    if (busy_cnt != LAST + hold_len) begin
      bad++; $display("FAIL %s_busy_len got=%0d exp=%0d", name, busy_cnt, LAST + hold_len);
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt);
    end
    total++;
    if (done_c != LAST + 1 + hold_len) begin
      bad++; $display("FAIL %s_done_cycle got=%0d exp=%0d", name, done_c, LAST + 1 + hold_len);
    end
    $display("%s: hold_at=%0d len=%0d stray_start=%0d done_c=%0d errors=%0d",
             name, hold_at, hold_len, extra_start, done_c, bad - b0);
  endtask

  task automatic test_full_run();
    run_seq("full", 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_stall();
    run_seq("stall", K0 + S + 4 * D + 9, 7, 0, 1'b0, 0);
  endtask

  task automatic test_start_busy();
    run_seq("start_busy", 0, 0, 100, 1'b0, 0);
  endtask

  task automatic test_start_under_hold();
    run_seq("start_hold", 0, 0, 0, 1'b1, 0);
  endtask

  task automatic test_random_hold();
    for (int r = 0; r < 3; r++) begin
      run_seq("rand_hold", int'($urandom_range(1, LAST)), int'($urandom_range(1, 12)),
              int'($urandom_range(2, 2000)), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_midrun_reset();
    int b0;
    run_seq("midrst", 0, 0, 0, 1'b0, S0 + S + int'($urandom_range(0, S - 1)));
    b0 = bad;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (obs !== 32'd0) begin
        bad++;
        $display("FAIL midrst_quiet cyc=%0d got=%h exp=%h", i, obs, 32'd0);
      end
    end
    $display("midrst_quiet: errors=%0d", bad - b0);
    run_seq("after_rst", 0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stall();
    test_start_busy();
    test_start_under_hold();
    test_random_hold();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
